// File: rtl/carpark_pkg.sv
// Shared types and default constants for the car park gate controller.
package carpark_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        OPEN_IN  = 2'd2,
        OPEN_OUT = 2'd3
    } state_e;

    localparam int unsigned DEF_CAPACITY     = 15;
    localparam int unsigned DEF_CNT_W        = 4;
    localparam logic [3:0]  DEF_PSWD         = 4'b1010;
    localparam int unsigned DEF_MAX_TRIES    = 3;
    localparam int unsigned DEF_LOCK_CYCLES  = 16;
    localparam int unsigned DEF_GATE_TIMEOUT = 32;

    // Lane ids double as bit positions in the arbiter request/grant vectors.
    localparam int unsigned LANE_ENTRY = 0;
    localparam int unsigned LANE_EXIT  = 1;
    localparam int unsigned N_LANES    = 2;

endpackage

// File: rtl/carpark_rr_arb.sv
// Two-requester round-robin arbiter; a tie goes to the lane not served last.
module carpark_rr_arb
    import carpark_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] req_i,
    input  logic               advance_i,
    output logic [N_LANES-1:0] gnt_c_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_c_o = '0;
        last_d  = last_q;
        if (req_i[LANE_ENTRY] && req_i[LANE_EXIT]) begin
            if (last_q == 1'(LANE_EXIT)) begin
                gnt_c_o[LANE_ENTRY] = 1'b1;
            end else begin
                gnt_c_o[LANE_EXIT] = 1'b1;
            end
        end else begin
            gnt_c_o = req_i;
        end
        if (advance_i && (gnt_c_o != '0)) begin
            last_d = gnt_c_o[LANE_EXIT] ? 1'(LANE_EXIT) : 1'(LANE_ENTRY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'(LANE_EXIT);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/carpark_gate_ctrl.sv
// Shared barrier gate controller: entry lane with password/lockout, exit lane,
// occupancy tracking against a fixed capacity.
module carpark_gate_ctrl
    import carpark_pkg::*;
#(
    parameter int unsigned CAPACITY     = DEF_CAPACITY,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter logic [3:0]  PSWD         = DEF_PSWD,
    parameter int unsigned MAX_TRIES    = DEF_MAX_TRIES,
    parameter int unsigned LOCK_CYCLES  = DEF_LOCK_CYCLES,
    parameter int unsigned GATE_TIMEOUT = DEF_GATE_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [3:0]       pswd,
    input  logic             pswd_valid,
    input  logic             pass_sensor,
    output logic             gate_open,
    output logic             grant_entry,
    output logic             grant_exit,
    output logic             pswd_ok,
    output logic             pswd_err,
    output logic             lockout,
    output logic             full,
    output logic [CNT_W-1:0] occupancy
);

    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned GT_W   = $clog2(GATE_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [GT_W-1:0]     gtmr_q, gtmr_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic                gate_open_q, grant_entry_q, grant_exit_q;
    logic                pswd_ok_q, pswd_ok_d, pswd_err_q, pswd_err_d;
    logic                lockout_q, full_q;

    logic                entry_elig;
    logic                exit_elig;
    logic [N_LANES-1:0]  arb_req;
    logic [N_LANES-1:0]  arb_gnt;

    assign entry_elig = entry_req && (occ_q != CNT_W'(CAPACITY)) && (lock_q == '0);
    assign exit_elig  = exit_req && (occ_q != '0);

    always_comb begin
        arb_req             = '0;
        arb_req[LANE_ENTRY] = entry_elig;
        arb_req[LANE_EXIT]  = exit_elig;
    end

    carpark_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_i     (arb_req),
        .advance_i (state_q == IDLE),
        .gnt_c_o   (arb_gnt)
    );

    // Next-state, counters and password pulses.
    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        occ_d      = occ_q;
        gtmr_d     = '0;
        pswd_ok_d  = 1'b0;
        pswd_err_d = 1'b0;
        lock_d     = (lock_q != '0) ? lock_q - LOCK_W'(1) : '0;

        unique case (state_q)
            IDLE: begin
                if (arb_gnt[LANE_ENTRY]) begin
                    state_d = CHECK;
                end else if (arb_gnt[LANE_EXIT]) begin
                    state_d = OPEN_OUT;
                end
            end
            CHECK: begin
                if (pswd_valid) begin
                    if (pswd == PSWD) begin
                        pswd_ok_d = 1'b1;
                        tries_d   = '0;
                        state_d   = OPEN_IN;
                    end else begin
                        pswd_err_d = 1'b1;
                        if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                            tries_d = '0;
                            lock_d  = LOCK_W'(LOCK_CYCLES);
                            state_d = IDLE;
                        end else begin
                            tries_d = tries_q + TRY_W'(1);
                        end
                    end
                end else if (!entry_req) begin
                    state_d = IDLE;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                gtmr_d = gtmr_q + GT_W'(1);
                // A pass in the timeout cycle still counts.
                if (pass_sensor) begin
                    if (state_q == OPEN_IN) begin
                        if (occ_q != CNT_W'(CAPACITY)) occ_d = occ_q + CNT_W'(1);
                    end else begin
                        if (occ_q != '0) occ_d = occ_q - CNT_W'(1);
                    end
                    state_d = IDLE;
                end else if (gtmr_q == GT_W'(GATE_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they track the state after the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tries_q       <= '0;
            lock_q        <= '0;
            gtmr_q        <= '0;
            occ_q         <= '0;
            gate_open_q   <= 1'b0;
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            pswd_ok_q     <= 1'b0;
            pswd_err_q    <= 1'b0;
            lockout_q     <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tries_q       <= tries_d;
            lock_q        <= lock_d;
            gtmr_q        <= gtmr_d;
            occ_q         <= occ_d;
            gate_open_q   <= (state_d == OPEN_IN) || (state_d == OPEN_OUT);
            grant_entry_q <= (state_d == CHECK) || (state_d == OPEN_IN);
            grant_exit_q  <= (state_d == OPEN_OUT);
            pswd_ok_q     <= pswd_ok_d;
            pswd_err_q    <= pswd_err_d;
            lockout_q     <= (lock_d != '0);
            full_q        <= (occ_d == CNT_W'(CAPACITY));
        end
    end

    assign gate_open   = gate_open_q;
    assign grant_entry = grant_entry_q;
    assign grant_exit  = grant_exit_q;
    assign pswd_ok     = pswd_ok_q;
    assign pswd_err    = pswd_err_q;
    assign lockout     = lockout_q;
    assign full        = full_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_carpark_gate_ctrl.sv
// Directed self-checking bench for carpark_gate_ctrl.
module tb_carpark_gate_ctrl;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic [3:0] pswd;
    logic       pswd_valid;
    logic       pass_sensor;
    logic       gate_open;
    logic       grant_entry;
    logic       grant_exit;
    logic       pswd_ok;
    logic       pswd_err;
    logic       lockout;
    logic       full;
    logic [3:0] occupancy;

    int checks = 0;
    int errors = 0;

    carpark_gate_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .pswd        (pswd),
        .pswd_valid  (pswd_valid),
        .pass_sensor (pass_sensor),
        .gate_open   (gate_open),
        .grant_entry (grant_entry),
        .grant_exit  (grant_exit),
        .pswd_ok     (pswd_ok),
        .pswd_err    (pswd_err),
        .lockout     (lockout),
        .full        (full),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Full entry transaction: grant, correct password, pass.
    task automatic do_entry();
        entry_req = 1'b1;
        tick();
        pswd = 4'b1010;
        pswd_valid = 1'b1;
        tick();
        pswd_valid = 1'b0;
        pass_sensor = 1'b1;
        entry_req = 1'b0;
        tick();
        pass_sensor = 1'b0;
    endtask

    task automatic do_exit();
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        pass_sensor = 1'b1;
        tick();
        pass_sensor = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        entry_req = 0; exit_req = 0; pswd = '0; pswd_valid = 0; pass_sensor = 0;
        apply_reset();
        outs = {gate_open, grant_entry, grant_exit, pswd_ok, pswd_err, lockout, full, occupancy};
        checks++;
        if (outs !== 11'd0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", outs); end
    endtask

    task automatic test_entry();
        entry_req = 1'b1;
        tick();
        checks++;
        if (grant_entry !== 1'b1 || gate_open !== 1'b0) begin
            errors++; $display("FAIL entry_grant: grant_entry=%b gate_open=%b expected 1/0", grant_entry, gate_open);
        end
        pswd = 4'b1010; pswd_valid = 1'b1;
        tick();
        checks++;
        if (pswd_ok !== 1'b1 || pswd_err !== 1'b0 || gate_open !== 1'b1) begin
            errors++; $display("FAIL entry_pswd_ok: ok=%b err=%b gate=%b expected 1/0/1", pswd_ok, pswd_err, gate_open);
        end
        pswd_valid = 1'b0;
        tick();
        checks++;
        if (pswd_ok !== 1'b0 || gate_open !== 1'b1) begin
            errors++; $display("FAIL entry_ok_pulse: ok=%b gate=%b expected 0/1", pswd_ok, gate_open);
        end
        pass_sensor = 1'b1; entry_req = 1'b0;
        tick();
        pass_sensor = 1'b0;
        checks++;
        if (occupancy !== 4'd1 || gate_open !== 1'b0 || grant_entry !== 1'b0) begin
            errors++; $display("FAIL entry_pass: occ=%0d gate=%b grant=%b expected 1/0/0", occupancy, gate_open, grant_entry);
        end
    endtask

    task automatic test_lockout();
        entry_req = 1'b1;
        tick();
        pswd = 4'b1110; pswd_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pswd_err !== 1'b1 || pswd_ok !== 1'b0) begin
                errors++; $display("FAIL lock_err_%0d: err=%b ok=%b expected 1/0", i, pswd_err, pswd_ok);
            end
            checks++;
            if (lockout !== (i == 3) || grant_entry !== (i != 3)) begin
                errors++; $display("FAIL lock_state_%0d: lockout=%b grant_entry=%b expected %b/%b",
                                   i, lockout, grant_entry, (i == 3), (i != 3));
            end
        end
        pswd_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++;
            if (lockout !== (k <= 15) || grant_entry !== (k == 17)) begin
                errors++; $display("FAIL lock_window_%0d: lockout=%b grant_entry=%b expected %b/%b",
                                   k, lockout, grant_entry, (k <= 15), (k == 17));
            end
            if (k == 1) begin
                checks++;
                if (pswd_err !== 1'b0) begin errors++; $display("FAIL lock_err_pulse: err=%b expected 0", pswd_err); end
            end
            if (k == 3) exit_req = 1'b1;
            if (k == 4) begin
                checks++;
                if (grant_exit !== 1'b1 || gate_open !== 1'b1) begin
                    errors++; $display("FAIL lock_exit_served: grant_exit=%b gate=%b expected 1/1", grant_exit, gate_open);
                end
                exit_req = 1'b0; pass_sensor = 1'b1;
            end
            if (k == 5) begin
                pass_sensor = 1'b0;
                checks++;
                if (occupancy !== 4'd0 || gate_open !== 1'b0) begin
                    errors++; $display("FAIL lock_exit_pass: occ=%0d gate=%b expected 0/0", occupancy, gate_open);
                end
            end
        end
        entry_req = 1'b0;
        tick();
        checks++;
        if (grant_entry !== 1'b0) begin errors++; $display("FAIL abandon: grant_entry=%b expected 0", grant_entry); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_entry(); do_entry(); do_entry();
        do_exit();
        checks++;
        if (occupancy !== 4'd2) begin errors++; $display("FAIL rr_setup_occ: got %0d expected 2", occupancy); end
        entry_req = 1'b1; exit_req = 1'b1;
        tick();
        checks++;
        if (grant_entry !== 1'b1 || grant_exit !== 1'b0) begin
            errors++; $display("FAIL rr_first: entry=%b exit=%b expected 1/0", grant_entry, grant_exit);
        end
        pswd = 4'b1010; pswd_valid = 1'b1;
        tick();
        pswd_valid = 1'b0; pass_sensor = 1'b1;
        tick();
        pass_sensor = 1'b0;
        checks++;
        if (occupancy !== 4'd3 || grant_entry !== 1'b0) begin
            errors++; $display("FAIL rr_entry_done: occ=%0d grant_entry=%b expected 3/0", occupancy, grant_entry);
        end
        tick();
        checks++;
        if (grant_exit !== 1'b1 || grant_entry !== 1'b0) begin
            errors++; $display("FAIL rr_second: entry=%b exit=%b expected 0/1", grant_entry, grant_exit);
        end
        exit_req = 1'b0; pass_sensor = 1'b1;
        tick();
        pass_sensor = 1'b0;
        checks++;
        if (occupancy !== 4'd2) begin errors++; $display("FAIL rr_exit_done: occ=%0d expected 2", occupancy); end
        tick();
        checks++;
        if (grant_entry !== 1'b1) begin errors++; $display("FAIL rr_third: grant_entry=%b expected 1", grant_entry); end
        entry_req = 1'b0;
        tick();
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 15; i++) do_entry();
        checks++;
        if (occupancy !== 4'd15 || full !== 1'b1) begin
            errors++; $display("FAIL full_reached: occ=%0d full=%b expected 15/1", occupancy, full);
        end
        entry_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant_entry !== 1'b0) begin errors++; $display("FAIL full_blocks_%0d: grant_entry=%b expected 0", i, grant_entry); end
        end
        entry_req = 1'b0;
        do_exit();
        checks++;
        if (occupancy !== 4'd14 || full !== 1'b0) begin
            errors++; $display("FAIL full_exit: occ=%0d full=%b expected 14/0", occupancy, full);
        end
    endtask

    task automatic test_timeout();
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        checks++;
        if (grant_exit !== 1'b1) begin errors++; $display("FAIL to_grant: grant_exit=%b expected 1", grant_exit); end
        for (int k = 1; k <= 32; k++) begin
            tick();
            checks++;
            if (gate_open !== (k <= 31)) begin
                errors++; $display("FAIL to_gate_%0d: gate=%b expected %b", k, gate_open, (k <= 31));
            end
        end
        checks++;
        if (occupancy !== 4'd14) begin errors++; $display("FAIL to_occ: occ=%0d expected 14", occupancy); end
        // Pass arriving exactly in the timeout cycle must be counted.
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        repeat (31) tick();
        checks++;
        if (gate_open !== 1'b1) begin errors++; $display("FAIL to_edge_open: gate=%b expected 1", gate_open); end
        pass_sensor = 1'b1;
        tick();
        checks++;
        if (occupancy !== 4'd13 || gate_open !== 1'b0) begin
            errors++; $display("FAIL to_pass_wins: occ=%0d gate=%b expected 13/0", occupancy, gate_open);
        end
        tick();
        pass_sensor = 1'b0;
        checks++;
        if (occupancy !== 4'd13) begin errors++; $display("FAIL stray_pass: occ=%0d expected 13", occupancy); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] outs;
        entry_req = 1'b1;
        tick();
        pswd = 4'b1010; pswd_valid = 1'b1;
        tick();
        pswd_valid = 1'b0;
        checks++;
        if (gate_open !== 1'b1) begin errors++; $display("FAIL mid_open: gate=%b expected 1", gate_open); end
        reset = 1'b1;
        tick();
        reset = 1'b0; entry_req = 1'b0;
        outs = {gate_open, grant_entry, grant_exit, pswd_ok, pswd_err, lockout, full, occupancy};
        checks++;
        if (outs !== 11'd0) begin errors++; $display("FAIL mid_reset: got %b expected 0", outs); end
        exit_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (grant_exit !== 1'b0 || gate_open !== 1'b0) begin
                errors++; $display("FAIL empty_exit_%0d: grant_exit=%b gate=%b expected 0/0", i, grant_exit, gate_open);
            end
        end
        exit_req = 1'b0;
        pswd = 4'b1010; pswd_valid = 1'b1;
        tick();
        pswd_valid = 1'b0;
        checks++;
        if (pswd_ok !== 1'b0 || grant_entry !== 1'b0) begin
            errors++; $display("FAIL idle_pswd_ignored: ok=%b grant=%b expected 0/0", pswd_ok, grant_entry);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_entry();
        test_lockout();
        test_back_to_back();
        test_full();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
